// File: rtl/glitch_filter.sv
// Glitch filter for the NAND output stage: 2-flop synchroniser, stability qualification,
// edge strobes and an optional saturating reject counter (enabled by GLITCH_FILTER_CNT_EN).
module glitch_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             dout,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          s1_r;
    logic          s2_r;
    logic [CW-1:0] cnt_r;
    logic          dout_r;
    logic          rise_r;
    logic          fall_r;
    logic          reject_s;

    // A qualification run that collapses back to the current level is a rejected glitch.
    assign reject_s = (s2_r == dout_r) && (cnt_r != CNT_ZERO);

    // Two-flop synchroniser for the asynchronous gate output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
        end
    end

    // Stability qualification; any return to the current level restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= CNT_ZERO;
            dout_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (s2_r == dout_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
                dout_r <= s2_r;
                cnt_r  <= CNT_ZERO;
                rise_r <= s2_r;
                fall_r <= ~s2_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign dout       = dout_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;

`ifdef GLITCH_FILTER_CNT_EN
    localparam logic [CNT_W-1:0] GCNT_MAX = {CNT_W{1'b1}};
    logic [CNT_W-1:0] gcnt_r;

    // Saturating reject counter; clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            gcnt_r <= {CNT_W{1'b0}};
        end else if (reject_s && (gcnt_r != GCNT_MAX)) begin
            gcnt_r <= gcnt_r + CNT_W'(1);
        end else begin
            gcnt_r <= gcnt_r;
        end
    end

    assign glitch_cnt = gcnt_r;
`else
    logic unused_cnt_s;

    assign unused_cnt_s = clr_cnt ^ reject_s;
    assign glitch_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_glitch_filter.sv
// Self-checking bench for glitch_filter: directed scenarios plus random pulse trains,
// compared every cycle against a run-length reference model.
module tb_glitch_filter;

    localparam int SC   = 4;
    localparam int GW   = 2;
    localparam int GMAX = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          dout;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [GW-1:0] glitch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the two synchroniser stages, the accepted level and the
    // current run of samples that disagree with it.
    bit m_s1, m_s2, m_dout, m_rise, m_fall;
    int m_gcnt;
    bit run_q[$];

    glitch_filter #(.STABLE_CYCLES(SC), .CNT_W(GW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .clr_cnt    (clr_cnt),
        .dout       (dout),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_gcnt();
`ifdef GLITCH_FILTER_CNT_EN
        return m_gcnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0;
        m_rise = 1'b0; m_fall = 1'b0; m_gcnt = 0;
        run_q.delete();
    endtask

    // One rising edge: a run of SC disagreeing samples is accepted, a shorter run that
    // ends by agreeing again is a rejected glitch.
    task automatic model_edge();
        bit s;
        bit rej;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s = m_s2;
        rej = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s == m_dout) begin
            rej = (run_q.size() > 0);
            run_q.delete();
        end else begin
            run_q.push_back(s);
            if (run_q.size() == SC) begin
                m_dout = s;
                m_rise = s;
                m_fall = !s;
                run_q.delete();
            end
        end
        if (clr_cnt) m_gcnt = 0;
        else if (rej && m_gcnt < GMAX) m_gcnt++;
        m_s2 = m_s1;
        m_s1 = din;
    endtask

    task automatic check_outs(input string tag);
        check_eq({tag, ".dout"}, {31'b0, dout}, {31'b0, m_dout});
        check_eq({tag, ".rise"}, {31'b0, rise_pulse}, {31'b0, m_rise});
        check_eq({tag, ".fall"}, {31'b0, fall_pulse}, {31'b0, m_fall});
        check_eq({tag, ".gcnt"}, {30'b0, glitch_cnt}, exp_gcnt());
        check_eq({tag, ".excl"}, {31'b0, rise_pulse & fall_pulse}, 32'd0);
    endtask

    task automatic step(input bit d, input bit clr = 1'b0, input string tag = "step");
        din = d;
        clr_cnt = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic run(input bit d, input int n, input string tag);
        for (int i = 0; i < n; i++) step(d, 1'b0, tag);
    endtask

    // Hold din high from the current negedge and measure edges until dout rises.
    task automatic measure_rise(input string tag);
        int lat = 0;
        int nrise = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, tag);
            if (dout === 1'b1 && lat == 0) lat = i;
            if (rise_pulse === 1'b1) nrise++;
        end
        check_eq({tag, ".latency"}, lat, 32'd6);
        check_eq({tag, ".rise_count"}, nrise, 32'd1);
    endtask

    task automatic async_reset_now(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs(tag);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        din = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reset_hold");
        rst_n = 1'b1;
        measure_rise("reset_release");

        // Falling edge, then two single-sample glitches back toward 1.
        run(1'b0, 10, "fall");
        step(1'b1, 1'b0, "fall_glitch1");
        run(1'b0, 5, "fall_glitch1");
        step(1'b1, 1'b0, "fall_glitch2");
        run(1'b0, 5, "fall_glitch2");

        // Short (2-sample) glitch and the 4/3-sample threshold cases.
        run(1'b1, 2, "short");
        run(1'b0, 6, "short");
        run(1'b1, 4, "thr4");
        run(1'b0, 10, "thr4");
        run(1'b1, 3, "thr3");
        run(1'b0, 6, "thr3");

        // Saturation, then clear on the same edge as a rejection.
        for (int g = 0; g < 5; g++) begin
            step(1'b1, 1'b0, "sat");
            run(1'b0, 4, "sat");
        end
        step(1'b1, 1'b0, "clr_glitch");
        step(1'b0, 1'b0, "clr_glitch");
        step(1'b0, 1'b0, "clr_glitch");
        step(1'b0, 1'b1, "clr_glitch");
        check_eq("clr_priority", {30'b0, glitch_cnt}, 32'd0);
        run(1'b0, 3, "clr_after");

        // Asynchronous reset while dout=1 and a fall is pending.
        run(1'b1, 8, "pre_async");
        run(1'b0, 4, "pre_async");
        async_reset_now("async_mid");
        check_eq("async_dout_now", {31'b0, dout}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "async_hold");
        rst_n = 1'b1;
        measure_rise("async_release");

        // Random pulse trains with occasional clears and asynchronous resets.
        for (int r = 0; r < 70; r++) begin
            bit lvl = 1'($urandom_range(0, 1));
            int len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++)
                step(lvl, ($urandom_range(0, 11) == 0), "rand");
            if ($urandom_range(0, 24) == 0) begin
                async_reset_now("rand_async");
                step(1'($urandom_range(0, 1)), 1'b0, "rand_async");
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/glitch_filter.md
Name: glitch_filter

Overview:
- Downstream consumer of the combinational NAND-gate output stage (signal `f_out`).
- Gate delays on that stage produce hazards and short glitches; this block removes them before any logic uses the signal.
- Synchronises the asynchronous input to `clk` and qualifies each level change by a stability count.
- Emits a clean level, single-cycle edge strobes and a saturating count of rejected glitches.

Parameters:
- STABLE_CYCLES, 4, number of consecutive synchronised samples a new level must hold before it is accepted; legal range >= 2.
- CNT_W, 8, width of the glitch counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous.
- din  input  1  raw, unsynchronised input (the `f_out` of the upstream gate stage).
- clr_cnt  input  1  synchronous clear of glitch_cnt.
- dout  output  1  filtered level.
- rise_pulse  output  1  one-cycle strobe when dout goes 0->1.
- fall_pulse  output  1  one-cycle strobe when dout goes 1->0.
- glitch_cnt  output  CNT_W  saturating count of rejected pulses.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync flops s1 and s2 = 0.
  - stability counter cnt = 0.
  - dout, rise_pulse and fall_pulse = 0.
  - glitch_cnt = 0.
- Synchroniser: two flops, s1<=din, s2<=s1. Only s2 is used downstream.
- cnt width is $clog2(STABLE_CYCLES). Evaluation each rising edge:
  - If s2==dout: cnt<=0. If cnt!=0 at that edge, a glitch is rejected and glitch_cnt increments.
  - Else if cnt==STABLE_CYCLES-1: dout<=s2 and cnt<=0. rise_pulse<=s2 (or fall_pulse<=~s2) on the same edge, so the strobe is high in the first cycle dout shows its new value.
  - Else: cnt<=cnt+1.
- rise_pulse and fall_pulse are 0 in every cycle not described above. They are never high together.
- Latency: with din changed and held before edge E0, dout updates on edge E0+STABLE_CYCLES+1. That is the (STABLE_CYCLES+2)th edge counting E0. For the default, 6 edges.
- Pulse rejection:
  - A level seen on s2 for k consecutive samples passes only if k >= STABLE_CYCLES.
  - A level with 1 <= k < STABLE_CYCLES is dropped and counted once.
- Re-toggle mid-count: if s2 returns to dout at any cnt value, the count restarts from 0 on the next difference. There is no partial credit.
- glitch_cnt:
  - Saturates at 2^CNT_W-1; further glitches leave it unchanged.
  - clr_cnt takes priority over increment in the same cycle: the result is 0.
- Reset mid-qualification: the pending change is discarded. After release, s2 refills from din. A din=1 then needs the full latency again before dout=1.
- All outputs are registered. There is no combinational path from din to any output.

Optional Feature:
- Macro: GLITCH_FILTER_CNT_EN.
- Defined: the glitch counter and clr_cnt logic are built as described above.
- Undefined:
  - glitch_cnt is tied to 0 and clr_cnt is ignored.
  - No counter flops are built.
  - Filtering, dout, rise_pulse, fall_pulse and latency are unchanged.
- The port list is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with din=1 for 3 cycles -> dout=0, both pulses 0, glitch_cnt=0. Then release and hold din=1 -> dout=1 exactly 6 edges after the first capturing edge, with rise_pulse high for exactly one cycle.
- Short glitch: clk period 10; din=1 for 20 time units (2 samples), then back to 0 -> dout stays 0, no pulses, glitch_cnt=1.
- Threshold: din=1 for exactly 4 samples (STABLE_CYCLES) -> dout rises. Separately, exactly 3 samples -> rejected and glitch_cnt increments by 1.
- Falling edge: from dout=1, din=0 held -> fall_pulse for one cycle 6 edges after the change, dout=0. Two 1-sample glitches back toward 1 during the steady-0 period -> glitch_cnt +2.
- Saturation and clear: CNT_W=2, inject 5 glitches -> glitch_cnt sticks at 3. Then assert clr_cnt on the same cycle as a 6th glitch's rejection -> glitch_cnt=0.
- Asynchronous reset mid-count: din=1 held, assert rst_n=0 off-edge after 2 samples -> outputs go 0 immediately without waiting for a clock edge, and no rise_pulse appears. After release, the full 6-edge latency is required again.
